// File: rtl/seq_divider_32.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned.
// Results are registered on entry to DONE and held until the next completion.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready=1, waiting for start
// CALC  | one restoring shift/subtract step per edge, WIDTH steps
// FIX   | apply result signs / divide-by-zero override, load outputs
// DONE  | done=1 for one cycle, then back to IDLE
module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] dvd_r;
  logic             sop_r;
  logic             dvs_sgn_r;
  logic             zero_r;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH+1:0] trial;
  logic             neg_q;
  logic             neg_r;

  assign dvd_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Two extra bits on the subtraction keep the borrow even when the shifted
  // partial remainder is at or above 2^WIDTH.
  assign trial = {rem_r, quo_r[WIDTH-1]} - {2'b00, dvs_r};

  assign neg_q = sop_r & (dvd_r[WIDTH-1] ^ dvs_sgn_r);
  assign neg_r = sop_r & dvd_r[WIDTH-1];

  assign ready = (state_r == S_IDLE);
  assign done  = (state_r == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dvs_r     <= '0;
      dvd_r     <= '0;
      sop_r     <= 1'b0;
      dvs_sgn_r <= 1'b0;
      zero_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r   <= S_CALC;
            cnt_r     <= CW'(WIDTH);
            rem_r     <= '0;
            quo_r     <= dvd_mag;
            dvs_r     <= dvs_mag;
            dvd_r     <= dividend;
            sop_r     <= signed_op;
            dvs_sgn_r <= divisor[WIDTH-1];
            zero_r    <= (divisor == '0);
          end
        end
        S_CALC: begin
          if (trial[WIDTH+1]) begin
            rem_r <= {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
          end else begin
            rem_r <= trial[WIDTH:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
          end
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= S_FIX;
          end
        end
        S_FIX: begin
          state_r <= S_DONE;
          if (zero_r) begin
            quotient  <= '1;
            remainder <= dvd_r;
            dbz       <= 1'b1;
          end else begin
            quotient  <= neg_q ? -quo_r : quo_r;
            remainder <= neg_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
            dbz       <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
